// File: rtl/muldiv_unit16.sv
// muldiv_unit16: iterative 16-bit multiply / unsigned divide unit.
// Multiply is a shift-add loop and divide is a restoring loop. Each loop
// produces one partial product or one quotient bit per cycle, for 16 cycles.
// The result is written back to a register-file port, and writes to r0 are
// suppressed.
module muldiv_unit16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       dest,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       wr_addr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         addr_q, addr_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   sel;
    logic               fin_live;

    // Select the final value for the latched op from the accumulators.
    always_comb begin
        sel = '0;
        case (op_q)
            2'b00:   sel = prod_q[WIDTH-1:0];
            2'b01:   sel = prod_q[2*WIDTH-1:WIDTH];
            2'b10:   sel = quo_q;
            default: sel = rem_q[WIDTH-1:0];
        endcase
    end

    // Next-state logic and datapath step for the multiply and divide loops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        addr_d   = addr_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        rem_sh   = {rem_q[WIDTH-1:0], a_q[LAST - cnt_q]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    addr_d = dest;
                    cnt_d  = '0;
                    prod_d = '0;
                    // Divide by zero skips the loop. The accumulators are
                    // preloaded with the quotient (all ones) and remainder (a)
                    // that a zero divisor defines.
                    if (op[1] && (b == '0)) begin
                        quo_d   = '1;
                        rem_d   = {1'b0, a};
                        state_d = FIN;
                    end else begin
                        quo_d   = '0;
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!op_q[1]) begin
                    if (b_q[cnt_q])
                        prod_d = prod_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
                end else begin
                    // Restoring step: bring in the next dividend bit, MSB
                    // first, and subtract the divisor when it fits.
                    if (rem_sh >= {1'b0, b_q}) begin
                        rem_d = rem_sh - {1'b0, b_q};
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = FIN;
            end
            FIN: begin
                result_d = sel;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. A synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addr_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            addr_q   <= addr_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    // Gating the FIN outputs with rst means an op aborted in FIN never
    // pulses done or wr_en.
    always_comb begin
        fin_live = (state_q == FIN) && !rst;
        busy     = (state_q != IDLE);
        done     = fin_live;
        result   = fin_live ? sel : result_q;
        wr_en    = fin_live && (addr_q != 4'd0);
        wr_addr  = addr_q;
    end

endmodule

// File: tb/tb_muldiv_unit16.sv
// Scoreboard bench for muldiv_unit16. The driver pushes the expected
// response when a start is accepted. A negedge monitor pops the queue on
// every done pulse and compares the response.
module tb_muldiv_unit16;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  dest;
    logic        busy, done, wr_en;
    logic [15:0] result;
    logic [3:0]  wr_addr;

    muldiv_unit16 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .dest(dest), .busy(busy), .done(done), .result(result),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  addr;
        logic        wen;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic, with divide by zero giving all ones / a.
    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        case (o)
            2'd0:    return p[15:0];
            2'd1:    return p[31:16];
            2'd2:    return (y == 16'd0) ? 16'hFFFF : x / y;
            default: return (y == 16'd0) ? x : x % y;
        endcase
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    exp_t mon_e;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_pulse_width", 32'(done_prev), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("wr_en", 32'(wr_en), 32'(mon_e.wen));
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
            end
        end else if (wr_en !== 1'b0) begin
            chk("wr_en_without_done", 32'(wr_en), 32'd0);
        end
        done_prev <= done;
    end

    // Called just after a negedge. Pushes an expectation only if the start will be accepted.
    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] d, input logic [15:0] r, input int lat);
        exp_t e;
        op = o; a = x; b = y; dest = d; start = 1'b1;
        if (!busy && !rst) begin
            e.res = r; e.addr = d; e.wen = (d != 4'd0); e.acc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); dest = 4'($urandom);
    endtask

    // Scramble operands while the unit is busy; they must not matter.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [15:0] rx, ry;
        logic [3:0]  rd;
        int          nd;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations, issued back to back.
        issue(2'd0, 16'd300, 16'd200, 4'd3, 16'hEA60, 17);   wait_idle();
        issue(2'd1, 16'h1234, 16'h5678, 4'd5, 16'h0626, 17); wait_idle();
        issue(2'd0, 16'h1234, 16'h5678, 4'd5, 16'h0060, 17); wait_idle();
        issue(2'd2, 16'd1000, 16'd7, 4'd2, 16'h008E, 17);    wait_idle();
        issue(2'd3, 16'd1000, 16'd7, 4'd2, 16'h0006, 17);    wait_idle();
        issue(2'd2, 16'h1234, 16'd0, 4'd4, 16'hFFFF, 1);     wait_idle();
        issue(2'd3, 16'h1234, 16'd0, 4'd4, 16'h1234, 1);     wait_idle();
        issue(2'd0, 16'd2, 16'd3, 4'd0, 16'h0006, 17);       wait_idle();
        chk("result_held", 32'(result), 32'h0006);

        // Reset during RUN: the op is aborted and never completes.
        issue(2'd0, 16'hFFFF, 16'hFFFF, 4'd7, 16'h0001, 17);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || wr_en !== 1'b0) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);

        // Second start during RUN is ignored; only the first result appears.
        issue(2'd2, 16'd1000, 16'd7, 4'd9, 16'h008E, 17);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; a = 16'd5; b = 16'd5; dest = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random operations, with occasional zero divisors and idle gaps.
        repeat (40) begin
            ro = 2'($urandom);
            rx = 16'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            rd = 4'($urandom);
            issue(ro, rx, ry, rd, model(ro, rx, ry), (ro[1] && ry == 16'd0) ? 1 : 17);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
